// File: rtl/alu_seq_pkg.sv
// Shared types for the register-file ALU sequencer.
// Op codes, FSM state names and default widths.
package alu_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_SHL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational 8-op ALU used by alu_sequencer.
// Carry is add carry-out, sub borrow or shifted-out bit.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  // Decode op into result and carry
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm;
      OP_MOV: result = a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer driving a 16x8 dual-read register file.
// Build option LDI_FAST_EN: LDI jumps straight from IDLE to WRITE.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Op_Valid,
  output logic              Op_Ready,
  input  logic [2:0]        Op_Code,
  input  logic [ADDR_W-1:0] Op_SrcA,
  input  logic [ADDR_W-1:0] Op_SrcB,
  input  logic [ADDR_W-1:0] Op_Dst,
  input  logic [DATA_W-1:0] Op_Imm,
  output logic [ADDR_W-1:0] Addr_A,
  output logic [ADDR_W-1:0] Addr_B,
  input  logic [DATA_W-1:0] Out_A,
  input  logic [DATA_W-1:0] Out_B,
  output logic [ADDR_W-1:0] Addr_WR,
  output logic              WR,
  output logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic              Zero,
  output logic              Carry
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_WRITE = WRITE;

  logic [1:0]        st;
  logic [1:0]        st_n;
  op_e               op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] imm_q;
  logic              accept;
  logic              fast;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_z;

  assign Op_Ready = (st == S_IDLE);
  assign accept   = Op_Valid && Op_Ready;
  assign WR       = (st == S_WRITE);
  assign Done     = (st == S_WRITE);

`ifdef LDI_FAST_EN
  assign fast = (Op_Code == OP_LDI);
`else
  assign fast = 1'b0;
`endif

  alu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .op     (op_q),
    .a      (Out_A),
    .b      (Out_B),
    .imm    (imm_q),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Next-state selection
  always_comb begin
    st_n = st;
    unique case (st)
      S_IDLE:  if (accept) st_n = fast ? S_WRITE : S_READ;
      S_READ:  st_n = S_EXEC;
      S_EXEC:  st_n = S_WRITE;
      S_WRITE: st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight op
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) st <= S_IDLE;
    else        st <= st_n;
  end

  // Capture the op fields at the accept edge only
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      op_q  <= OP_ADD;
      dst_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= op_e'(Op_Code);
      dst_q <= Op_Dst;
      imm_q <= Op_Imm;
    end
  end

  // Read addresses load on accept and hold afterwards
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Addr_A <= '0;
      Addr_B <= '0;
    end else if (accept && !fast) begin
      Addr_A <= Op_SrcA;
      Addr_B <= Op_SrcB;
    end
  end

  // Result, flags and write address register in EXEC
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DIN     <= '0;
      Zero    <= 1'b0;
      Carry   <= 1'b0;
      Addr_WR <= '0;
    end else if (st == S_EXEC) begin
      DIN     <= alu_res;
      Zero    <= alu_z;
      Carry   <= alu_c;
      Addr_WR <= dst_q;
    end else if (accept && fast) begin
      DIN     <= Op_Imm;
      Zero    <= ~|Op_Imm;
      Carry   <= 1'b0;
      Addr_WR <= Op_Dst;
    end
  end

endmodule
